// File: rtl/xillybus_w_packer_if.sv
// Host write-stream and packed-beat handshake bundle for xillybus_w_packer.
interface xillybus_w_packer_if #(
  parameter int unsigned WORDS = 4
);
  logic                  user_w_w_wren;
  logic [31:0]           user_w_w_data;
  logic                  user_w_w_open;
  logic                  user_w_w_full;
  logic [32*WORDS-1:0]   out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  // Environment side: Xillybus core plus downstream consumer
  modport master (
    output user_w_w_wren, user_w_w_data, user_w_w_open, out_ready,
    input  user_w_w_full, out_data, out_valid, out_last
  );

  // Packer side
  modport slave (
    input  user_w_w_wren, user_w_w_data, user_w_w_open, out_ready,
    output user_w_w_full, out_data, out_valid, out_last
  );
endinterface

// File: rtl/xillybus_w_packer.sv
// Xillybus 32-bit write-stream sink: FIFO-buffers words and packs WORDS of them per
// output beat, flushing a zero-padded partial beat and marking the last beat on close.
module xillybus_w_packer #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   bus_clk,
  input  logic                   bus_rst,
  xillybus_w_packer_if.slave     w,
  output logic                   stream_done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(WORDS);
  localparam int unsigned BW = 32 * WORDS;

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full_q;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            closing_q, closing_d;
  logic            open_q;
  logic            ovf_q;

  logic            wr_acc_c;
  logic            pop_c;
  logic            empty_c;
  logic            open_fall_c;
  logic            open_rise_c;
  logic [31:0]     rd_word_c;
  logic [CW-1:0]   count_nxt_c;

  assign wr_acc_c    = w.user_w_w_wren && !full_q;
  assign empty_c     = (count_q == '0);
  assign open_fall_c = open_q && !w.user_w_w_open;
  assign open_rise_c = !open_q && w.user_w_w_open;
  assign rd_word_c   = mem[rd_ptr_q];
  assign count_nxt_c = count_q + CW'(wr_acc_c) - CW'(pop_c);

  // FIFO storage: contents need no reset, pointers define validity
  always_ff @(posedge bus_clk) begin
    if (wr_acc_c) mem[wr_ptr_q] <= w.user_w_w_data;
  end

  // FIFO pointers, occupancy and registered full flag
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)    rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_nxt_c;
      full_q  <= (count_nxt_c == CW'(DEPTH));
    end
  end

  // Packer next-state: pops one word per cycle into the lane register
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    closing_d = closing_q;
    pop_c     = 1'b0;

    unique case (state_q)
      FILL: begin
        if (!empty_c) begin
          pop_c = 1'b1;
          data_d[32*idx_q +: 32] = rd_word_c;
          if (idx_q == IW'(WORDS - 1)) begin
            idx_d   = '0;
            valid_d = 1'b1;
            state_d = HOLD;
            // Last only if this word is the stream's final one already in hand
            last_d  = (closing_q || open_fall_c) && (count_q == CW'(1)) && !wr_acc_c;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (closing_q && !w.user_w_w_open) begin
          if (idx_q != '0) begin
            for (int unsigned l = 0; l < WORDS; l++) begin
              if (IW'(l) >= idx_q) data_d[32*l +: 32] = 32'h0;
            end
            idx_d   = '0;
            valid_d = 1'b1;
            last_d  = 1'b1;
            state_d = HOLD;
          end else begin
            done_d    = 1'b1;
            closing_d = 1'b0;
          end
        end
      end
      HOLD: begin
        if (valid_q && w.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = FILL;
          if (last_q) begin
            done_d    = 1'b1;
            closing_d = 1'b0;
          end
          // Start the next beat in the handshake cycle for full throughput
          if (!empty_c) begin
            pop_c        = 1'b1;
            data_d[31:0] = rd_word_c;
            idx_d        = IW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase

    if (open_fall_c) closing_d = 1'b1;
    if (open_rise_c) closing_d = 1'b0;
  end

  // Packer and status registers
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      closing_q <= 1'b0;
      open_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      closing_q <= closing_d;
      open_q    <= w.user_w_w_open;
      if (w.user_w_w_wren && full_q) ovf_q <= 1'b1;
      else if (open_rise_c)          ovf_q <= 1'b0;
    end
  end

  assign w.user_w_w_full = full_q;
  assign w.out_data      = data_q;
  assign w.out_valid     = valid_q;
  assign w.out_last      = last_q;
  assign stream_done     = done_q;
  assign overflow        = ovf_q;
  assign fifo_count      = count_q;

endmodule

// File: tb/tb_xillybus_w_packer.sv
// Self-checking bench for xillybus_w_packer: table-driven streams plus hand-written
// back-pressure, overflow and reset sequences, scored against a packing model.
module tb_xillybus_w_packer;

  localparam int unsigned WORDS = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned BW    = 32 * WORDS;

  logic          bus_clk = 1'b0;
  logic          bus_rst;
  logic          stream_done;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  xillybus_w_packer_if #(.WORDS(WORDS)) w ();

  xillybus_w_packer #(.WORDS(WORDS), .DEPTH(DEPTH)) dut (
    .bus_clk     (bus_clk),
    .bus_rst     (bus_rst),
    .w           (w),
    .stream_done (stream_done),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int unsigned n;
    logic [31:0] base;
    bit          close;
    int unsigned exp_beats;
    int unsigned exp_done;
  } vec_t;

  beat_t       sbq[$];
  vec_t        vecs[7];
  logic [31:0] acc [WORDS];
  int unsigned acc_n = 0;
  int          checks = 0;
  int          failures = 0;
  int unsigned beats_seen = 0;
  int unsigned done_seen = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge bus_clk);
      #1;
    end
  endtask

  task automatic push_beat(input logic last);
    beat_t b;
    for (int unsigned i = 0; i < WORDS; i++)
      b.data[32*i +: 32] = (i < acc_n) ? acc[i] : 32'h0;
    b.last = last;
    sbq.push_back(b);
    acc_n = 0;
  endtask

  task automatic model_word(input logic [31:0] d);
    acc[acc_n] = d;
    acc_n++;
    if (acc_n == WORDS) push_beat(1'b0);
  endtask

  // One write per call; the host model never strobes while full is high
  task automatic send(input logic [31:0] d);
    int guard = 0;
    while (w.user_w_w_full && guard < 500) begin
      w.user_w_w_wren = 1'b0;
      tick(1);
      guard++;
    end
    if (guard >= 500) begin
      checks++;
      failures++;
      $display("FAIL send_full_timeout actual=full required=not_full");
    end else begin
      w.user_w_w_wren = 1'b1;
      w.user_w_w_data = d;
      model_word(d);
      tick(1);
    end
  endtask

  task automatic close_stream(input bit tail_last);
    beat_t b;
    w.user_w_w_wren = 1'b0;
    w.user_w_w_open = 1'b0;
    if (acc_n > 0) begin
      push_beat(1'b1);
    end else if (tail_last && sbq.size() > 0) begin
      b = sbq.pop_back();
      b.last = 1'b1;
      sbq.push_back(b);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (!(sbq.size() == 0 && fifo_count == '0 && !w.out_valid) && guard < 300) begin
      tick(1);
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=pending%0d required=0", sbq.size());
    end
    tick(4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_full"},     BW'(w.user_w_w_full), BW'(0));
    check({tag, "_valid"},    BW'(w.out_valid),     BW'(0));
    check({tag, "_last"},     BW'(w.out_last),      BW'(0));
    check({tag, "_done"},     BW'(stream_done),     BW'(0));
    check({tag, "_overflow"}, BW'(overflow),        BW'(0));
    check({tag, "_count"},    BW'(fifo_count),      BW'(0));
    check({tag, "_data"},     w.out_data,           BW'(0));
  endtask

  // Output monitor: scores each handshake and the pulse that must follow a last beat
  initial begin
    beat_t e;
    logic  prev_last_hs = 1'b0;
    forever begin
      @(negedge bus_clk);
      if (bus_rst) begin
        prev_last_hs = 1'b0;
      end else begin
        if (prev_last_hs) check("done_after_last", BW'(stream_done), BW'(1));
        if (stream_done) done_seen++;
        prev_last_hs = w.out_valid && w.out_ready && w.out_last;
        if (w.out_valid && w.out_ready) begin
          beats_seen++;
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h required=none", w.out_data);
          end else begin
            e = sbq.pop_front();
            check("beat_data", w.out_data, e.data);
            check("beat_last", BW'(w.out_last), BW'(e.last));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b0;
    int unsigned d0;

    vecs[0] = '{4,  32'h0000_0001, 1'b0, 1, 0};
    vecs[1] = '{2,  32'h0000_000A, 1'b1, 1, 1};
    vecs[2] = '{8,  32'h0000_0100, 1'b1, 2, 1};
    vecs[3] = '{7,  32'h0000_0200, 1'b1, 2, 1};
    vecs[4] = '{0,  32'h0000_0000, 1'b1, 0, 1};
    vecs[5] = '{5,  32'h0000_0300, 1'b1, 2, 1};
    vecs[6] = '{12, 32'h0000_0400, 1'b0, 3, 0};

    bus_rst         = 1'b1;
    w.user_w_w_wren = 1'b0;
    w.user_w_w_data = 32'h0;
    w.user_w_w_open = 1'b1;
    w.out_ready     = 1'b1;
    tick(2);
    check_reset_outputs("reset");
    bus_rst = 1'b0;
    tick(2);

    // Continuous-rate streams with closes at varying beat alignments
    foreach (vecs[v]) begin
      b0 = beats_seen;
      d0 = done_seen;
      for (int unsigned i = 0; i < vecs[v].n; i++) send(vecs[v].base + i);
      if (vecs[v].close) close_stream(vecs[v].n > 0);
      else w.user_w_w_wren = 1'b0;
      drain();
      check($sformatf("vec%0d_beats", v), BW'(beats_seen - b0), BW'(vecs[v].exp_beats));
      check($sformatf("vec%0d_done", v),  BW'(done_seen - d0),  BW'(vecs[v].exp_done));
      if (vecs[v].close) begin
        w.user_w_w_open = 1'b1;
        tick(2);
      end
    end

    // Back-pressure: 4 words parked in the beat register, 16 fill the FIFO
    w.out_ready = 1'b0;
    b0 = beats_seen;
    for (int unsigned i = 0; i < 20; i++) send(32'h1000 + i);
    w.user_w_w_wren = 1'b0;
    tick(1);
    check("bp_full",     BW'(w.user_w_w_full), BW'(1));
    check("bp_count",    BW'(fifo_count),      BW'(DEPTH));
    check("bp_overflow", BW'(overflow),        BW'(0));
    w.out_ready = 1'b1;
    drain();
    check("bp_beats",      BW'(beats_seen - b0), BW'(5));
    check("bp_count_zero", BW'(fifo_count),      BW'(0));
    check("bp_full_clear", BW'(w.user_w_w_full), BW'(0));

    // Overflow: forced strobe while full is dropped and sets the sticky flag
    w.out_ready = 1'b0;
    b0 = beats_seen;
    for (int unsigned i = 0; i < 20; i++) send(32'h2000 + i);
    w.user_w_w_wren = 1'b1;
    w.user_w_w_data = 32'h0000_DEAD;
    tick(1);
    w.user_w_w_wren = 1'b0;
    tick(1);
    check("ovf_set",   BW'(overflow),   BW'(1));
    check("ovf_count", BW'(fifo_count), BW'(DEPTH));
    w.out_ready = 1'b1;
    drain();
    check("ovf_beats",  BW'(beats_seen - b0), BW'(5));
    check("ovf_sticky", BW'(overflow),        BW'(1));
    d0 = done_seen;
    b0 = beats_seen;
    close_stream(1'b0);
    tick(4);
    check("close_empty_done",  BW'(done_seen - d0),  BW'(1));
    check("close_empty_beats", BW'(beats_seen - b0), BW'(0));
    w.user_w_w_open = 1'b1;
    tick(2);
    check("ovf_cleared", BW'(overflow), BW'(0));

    // Reset mid-beat discards the partial words
    b0 = beats_seen;
    send(32'h3000);
    send(32'h3001);
    w.user_w_w_wren = 1'b0;
    tick(2);
    bus_rst = 1'b1;
    acc_n = 0;
    #1;
    check_reset_outputs("midrst");
    tick(1);
    bus_rst = 1'b0;
    tick(1);
    for (int unsigned i = 0; i < 4; i++) send(32'h4000 + i);
    w.user_w_w_wren = 1'b0;
    drain();
    check("midrst_beats", BW'(beats_seen - b0), BW'(1));
    check("sb_empty",     BW'(sbq.size()),      BW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
